// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types for the data-cache line memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int LINE_W = 128;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [25:0]       line_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Cache-side refill/writeback bus between the data cache and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if;
    import dmem_pkg::*;

    logic       reqD_mem;
    logic       reqD_cache_write;
    line_addr_t reqAddrD_mem;
    line_t      data_to_mem;
    line_t      data_from_mem;
    logic       read_ready_from_mem;
    logic       written_data_ack;
    logic       mem_busy;

    modport master (
        output reqD_mem, reqD_cache_write, reqAddrD_mem, data_to_mem,
        input  data_from_mem, read_ready_from_mem, written_data_ack, mem_busy
    );

    modport slave (
        input  reqD_mem, reqD_cache_write, reqAddrD_mem, data_to_mem,
        output data_from_mem, read_ready_from_mem, written_data_ack, mem_busy
    );

endinterface

`default_nettype wire

// File: rtl/dmem_line_array.sv
// ============================================================================
// Module   : dmem_line_array
// Purpose  : Single-port synchronous line storage, registered read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  wire logic                  clk,
    input  wire logic                  en_i,
    input  wire logic                  we_i,
    input  wire logic [DEPTH_LOG2-1:0] addr_i,
    input  wire line_t                 wdata_i,
    output line_t                      rdata_o
);

    line_t lines_q [2**DEPTH_LOG2];
    line_t rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                lines_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= lines_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Fixed-latency line read/writeback responder for the data cache.
//            Optional DMEM_STATS_EN adds rd_count/wr_count completion counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5,
    parameter int LINE_W     = 128
) (
    input  wire logic           clk,
    input  wire logic           reset,
    data_mem_responder_if.slave bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
`endif
);

    dmem_state_e           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic                  wr_q, wr_d;
    logic [LINE_W-1:0]     data_q, data_d;
    logic                  rd_valid_q;
    logic                  w_mem_go;
    logic                  w_mem_en;
    line_t                 w_rdata;
    logic                  w_unused_addr_hi;

    assign w_unused_addr_hi = ^bus.reqAddrD_mem[25:DEPTH_LOG2];

    // The *_d latch values feed the array directly so LATENCY=1 can use the
    // live request in the acceptance edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        data_d   = data_q;
        w_mem_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.reqD_mem) begin
                    addr_d = bus.reqAddrD_mem[DEPTH_LOG2-1:0];
                    wr_d   = bus.reqD_cache_write;
                    data_d = bus.data_to_mem;
                    cnt_d  = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d  = RESP;
                        w_mem_go = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
                if (cnt_q <= 8'd1) begin
                    state_d  = RESP;
                    w_mem_go = 1'b1;
                end
            end
            RESP: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!bus.reqD_mem) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset on the RESP edge must not let an in-flight write commit.
    assign w_mem_en = w_mem_go && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            if (w_mem_en && !wr_d) begin
                rd_valid_q <= 1'b1;
            end
        end
    end

    dmem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_lines (
        .clk     (clk),
        .en_i    (w_mem_en),
        .we_i    (wr_d),
        .addr_i  (addr_d),
        .wdata_i (line_t'(data_d)),
        .rdata_o (w_rdata)
    );

    assign bus.data_from_mem       = rd_valid_q ? w_rdata : '0;
    assign bus.read_ready_from_mem = (state_q == RESP) && !wr_q;
    assign bus.written_data_ack    = (state_q == RESP) && wr_q;
    assign bus.mem_busy            = (state_q != IDLE);

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            if (bus.read_ready_from_mem) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (bus.written_data_ack) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed + randomized self-checking bench for data_mem_responder.
//            Stats counters are checked when DMEM_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    data_mem_responder_if bus ();

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    data_mem_responder #(
        .DEPTH_LOG2 (DEPTH),
        .LATENCY    (LAT),
        .LINE_W     (128)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave)
`ifdef DMEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: line contents, which lines hold known data, pulse tallies.
    logic [127:0] mem_m   [2**DEPTH];
    bit           known_m [2**DEPTH];
    int           rd_m;
    int           wr_m;
    int           n_tests;
    int           n_fail;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = extra cycles the request stays high after
    // the response before it is dropped.
    task automatic do_req(input bit wr, input logic [25:0] addr,
                          input logic [127:0] data, input int hold);
        int k;
        int idx;
        idx = int'(addr[DEPTH-1:0]);
        @(negedge clk);
        bus.reqD_mem         = 1'b1;
        bus.reqD_cache_write = wr;
        bus.reqAddrD_mem     = addr;
        bus.data_to_mem      = data;
        @(posedge clk); #1;
        chk("busy_at_accept", 128'(bus.mem_busy), 128'd1);
        k = 0;
        while (!(bus.read_ready_from_mem || bus.written_data_ack) && k < 300) begin
            @(negedge clk);
            bus.reqD_cache_write = 1'($urandom);
            bus.reqAddrD_mem     = 26'($urandom);
            bus.data_to_mem      = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 128'(k), 128'(LAT - 1));
        if (wr) begin
            chk("wr_ack", 128'(bus.written_data_ack), 128'd1);
            chk("wr_no_rd", 128'(bus.read_ready_from_mem), 128'd0);
            mem_m[idx]   = data;
            known_m[idx] = 1'b1;
            wr_m++;
        end else begin
            chk("rd_ready", 128'(bus.read_ready_from_mem), 128'd1);
            chk("rd_no_ack", 128'(bus.written_data_ack), 128'd0);
            chk("rd_data", bus.data_from_mem, mem_m[idx]);
            rd_m++;
        end
        @(posedge clk); #1;
        chk("pulse_one_cycle", 128'({bus.read_ready_from_mem, bus.written_data_ack}), 128'd0);
        chk("busy_in_release", 128'(bus.mem_busy), 128'd1);
        if (!wr) chk("rd_data_held", bus.data_from_mem, mem_m[idx]);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("held_no_pulse", 128'({bus.read_ready_from_mem, bus.written_data_ack,
                                       bus.mem_busy}), 128'b001);
        end
        @(negedge clk);
        bus.reqD_mem = 1'b0;
        @(posedge clk); #1;
        chk("release_exit", 128'(bus.mem_busy), 128'd0);
    endtask

    initial begin
        logic [127:0] pat_a;
        logic [127:0] pat_x;
        logic [127:0] pat_y;
        logic [127:0] pat_z;
        logic [25:0]  ra;
        logic [127:0] rd;
        bit           rw;

        n_tests = 0;
        n_fail  = 0;
        rd_m    = 0;
        wr_m    = 0;
        for (int i = 0; i < 2**DEPTH; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = '0;
        end
        pat_a = {16{8'hA5}};
        pat_x = {$urandom, $urandom, $urandom, $urandom};
        pat_y = {$urandom, $urandom, $urandom, $urandom};
        pat_z = ~pat_y;

        bus.reqD_mem         = 1'b0;
        bus.reqD_cache_write = 1'b0;
        bus.reqAddrD_mem     = '0;
        bus.data_to_mem      = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 128'(bus.mem_busy), 128'd0);
        chk("reset_rd_ready", 128'(bus.read_ready_from_mem), 128'd0);
        chk("reset_wr_ack", 128'(bus.written_data_ack), 128'd0);
        chk("reset_data", bus.data_from_mem, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // Writeback then read-back, plus the A5 writeback.
        do_req(1'b1, 26'd3, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
        do_req(1'b0, 26'd3, 128'd0, 0);
        do_req(1'b1, 26'h7, pat_a, 0);
        do_req(1'b0, 26'h7, 128'd0, 0);

        // Held request: one response only, then a one-cycle drop re-arms.
        do_req(1'b0, 26'd3, 128'd0, 20);
        do_req(1'b0, 26'h7, 128'd0, 0);

        // Upper address bits alias onto the same line.
        do_req(1'b1, 26'h105, pat_x, 0);
        do_req(1'b0, 26'h005, 128'd0, 0);

        // Reset during BUSY drops the write and any pulse.
        do_req(1'b1, 26'd9, pat_z, 0);
        @(negedge clk);
        bus.reqD_mem         = 1'b1;
        bus.reqD_cache_write = 1'b1;
        bus.reqAddrD_mem     = 26'd9;
        bus.data_to_mem      = pat_y;
        @(posedge clk);
        @(negedge clk);
        bus.reqD_mem = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", 128'(bus.mem_busy), 128'd0);
        chk("midrst_data_clr", bus.data_from_mem, 128'd0);
        rd_m = 0;
        wr_m = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", 128'({bus.read_ready_from_mem, bus.written_data_ack,
                                         bus.mem_busy}), 128'd0);
        end
        do_req(1'b0, 26'd9, 128'd0, 0);

        // Randomized traffic; reads only target lines the model knows.
        for (int t = 0; t < 25; t++) begin
            ra = 26'($urandom);
            rd = {$urandom, $urandom, $urandom, $urandom};
            rw = 1'($urandom);
            if (!known_m[int'(ra[DEPTH-1:0])]) rw = 1'b1;
            do_req(rw, ra, rd, int'($urandom_range(0, 3)));
        end

`ifdef DMEM_STATS_EN
        chk("stat_rd", 128'(rd_count), 128'(rd_m));
        chk("stat_wr", 128'(wr_count), 128'(wr_m));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("stat_rd_rst", 128'(rd_count), 128'd0);
        chk("stat_wr_rst", 128'(wr_count), 128'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
